// File: rtl/uart_frame_ctrl_pkg.sv
// rtl/uart_frame_ctrl_pkg.sv - shared state encoding, error codes and UART timing constants
package uart_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK,
    S_WRITE
  } state_t;

  localparam logic [1:0] ERR_OVR = 2'b00;
  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  localparam logic [7:0] SYNC_DEFAULT = 8'hAA;
  localparam int CLKS_PER_BIT = 868;
  // Four 10-bit characters of silence between bytes ends the frame.
  localparam int TIMEOUT_DEFAULT = 4 * 10 * CLKS_PER_BIT;

endpackage

// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - UART byte-stream frame parser that writes validated payloads to a register file
module uart_frame_ctrl
  import uart_frame_ctrl_pkg::*;
#(
  parameter int         MAX_LEN      = 8,
  parameter int         TIMEOUT_CLKS = TIMEOUT_DEFAULT,
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int          IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  // Firing one count early puts err exactly TIMEOUT_CLKS cycles after the last strobe.
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CLKS - 2);

  state_t      state;
  logic [7:0]  base;
  logic [7:0]  len;
  logic [7:0]  idx;
  logic [7:0]  nidx;
  logic [7:0]  chk;
  logic [31:0] tmo_cnt;
  logic        ovr_pend;
  logic [7:0]  data_buf [MAX_LEN];

  assign nidx = idx + 8'd1;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= 8'd0;
      wr_data    <= 8'd0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      base       <= 8'd0;
      len        <= 8'd0;
      idx        <= 8'd0;
      chk        <= 8'd0;
      tmo_cnt    <= 32'd0;
      ovr_pend   <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      // An overrun on the final write cycle is reported one cycle after frame_done.
      if (ovr_pend) begin
        err      <= 1'b1;
        err_code <= ERR_OVR;
        ovr_pend <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (rx_valid && rx_byte == SYNC_BYTE) begin
            state   <= S_ADDR;
            tmo_cnt <= 32'd0;
          end
        end
        S_ADDR, S_LEN, S_DATA, S_CHK: begin
          if (rx_valid) begin
            tmo_cnt <= 32'd0;
            case (state)
              S_ADDR: begin
                base  <= rx_byte;
                chk   <= rx_byte;
                state <= S_LEN;
              end
              S_LEN: begin
                if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
                  err      <= 1'b1;
                  err_code <= ERR_LEN;
                  state    <= S_IDLE;
                end else begin
                  len   <= rx_byte;
                  chk   <= chk ^ rx_byte;
                  idx   <= 8'd0;
                  state <= S_DATA;
                end
              end
              S_DATA: begin
                data_buf[idx[IW-1:0]] <= rx_byte;
                chk <= chk ^ rx_byte;
                idx <= nidx;
                if (nidx == len) state <= S_CHK;
              end
              default: begin
                if (rx_byte == chk) begin
                  state   <= S_WRITE;
                  idx     <= 8'd0;
                  wr_en   <= 1'b1;
                  wr_addr <= base;
                  wr_data <= data_buf[0];
                end else begin
                  err      <= 1'b1;
                  err_code <= ERR_CHK;
                  state    <= S_IDLE;
                end
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            err      <= 1'b1;
            err_code <= ERR_TMO;
            tmo_cnt  <= 32'd0;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        S_WRITE: begin
          if (rx_valid) begin
            if (nidx == len) begin
              ovr_pend <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_OVR;
            end
          end
          if (nidx == len) begin
            frame_done <= 1'b1;
            idx        <= 8'd0;
            state      <= S_IDLE;
          end else begin
            wr_en   <= 1'b1;
            idx     <= nidx;
            wr_addr <= base + nidx;
            wr_data <= data_buf[nidx[IW-1:0]];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
